// File: rtl/alu_seq.sv
// Command sequencer for an external 4-bit ALU: registers operands, captures the
// result into an accumulator and holds it under valid/ready backpressure.
module alu_seq #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic [1:0]       in_op,
  input  logic             in_acc,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [1:0]       alu_op,
  input  logic [3:0]       alu_result,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_result,
  output logic             out_zero,
  output logic [3:0]       acc,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StHold = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [3:0]       alu_a_q, alu_b_q, out_result_q, acc_q;
  logic [1:0]       alu_op_q;
  logic             out_zero_q;
  logic [CNT_W-1:0] op_count_q;

  logic accept, capture, release_res;

  assign accept      = (state_q == StIdle) && in_valid;
  assign capture     = (state_q == StExec);
  assign release_res = (state_q == StHold) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StIdle;
    case (state_q)
      StIdle:  state_d = in_valid ? StExec : StIdle;
      StExec:  state_d = StHold;
      StHold:  state_d = out_ready ? StIdle : StHold;
      // The unused encoding falls back to idle.
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StHold);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q      <= 4'd0;
      alu_b_q      <= 4'd0;
      alu_op_q     <= 2'b00;
      out_result_q <= 4'd0;
      out_zero_q   <= 1'b0;
      acc_q        <= 4'd0;
      op_count_q   <= '0;
    end else begin
      if (accept) begin
        // Accept and capture never share an edge, so acc_q is the settled value.
        alu_a_q  <= in_acc ? acc_q : in_a;
        alu_b_q  <= in_b;
        alu_op_q <= in_op;
      end
      if (capture) begin
        out_result_q <= alu_result;
        out_zero_q   <= alu_zero;
        acc_q        <= alu_result;
      end
      if (release_res) begin
        op_count_q <= op_count_q + CNT_W'(1);
      end
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign out_result = out_result_q;
  assign out_zero   = out_zero_q;
  assign acc        = acc_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, hand-written
// multi-cycle sequences and randomized commands against a behavioural model.
module tb_alu_seq;

  localparam int unsigned CNT_W = 2;
  localparam int unsigned CMOD  = 4;

  logic             clk, rst_n;
  logic             in_valid, in_ready, in_acc;
  logic [3:0]       in_a, in_b;
  logic [1:0]       in_op;
  logic [3:0]       alu_a, alu_b, alu_result;
  logic [1:0]       alu_op;
  logic             alu_zero;
  logic             out_valid, out_ready, out_zero;
  logic [3:0]       out_result, acc;
  logic [CNT_W-1:0] op_count;

  int n_cmp = 0;
  int n_bad = 0;
  int m_acc = 0;
  int m_cnt = 0;

  alu_seq #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_acc    (in_acc),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_result(alu_result),
    .alu_zero  (alu_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_zero  (out_zero),
    .acc       (acc),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_alu(input int op, input int a, input int b);
    case (op)
      0:       return (a + b) % 16;
      1:       return (a - b + 16) % 16;
      2:       return a & b;
      default: return a | b;
    endcase
  endfunction

  // Stand-in for the downstream combinational ALU.
  always_comb begin
    alu_result = 4'(ref_alu(int'(alu_op), int'(alu_a), int'(alu_b)));
    alu_zero   = (alu_result == 4'd0);
  end

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle; runs one command end to end.
  task automatic run_cmd(input int a, input int b, input int op, input int accsel,
                         input int stall, output int got_res, output int got_zero);
    int exp_a, exp_r;
    exp_a = accsel ? m_acc : a;
    exp_r = ref_alu(op, exp_a, b);
    in_valid = 1'b1;
    in_a = 4'(a);
    in_b = 4'(b);
    in_op = 2'(op);
    in_acc = accsel[0];
    out_ready = 1'b0;
    check("in_ready_idle", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("alu_a", int'(alu_a), exp_a);
    check("alu_b", int'(alu_b), b);
    check("alu_op", int'(alu_op), op);
    check("exec_in_ready", int'(in_ready), 0);
    check("exec_out_valid", int'(out_valid), 0);
    tick();
    check("out_valid_set", int'(out_valid), 1);
    check("out_result", int'(out_result), exp_r);
    check("out_zero", int'(out_zero), int'(exp_r == 0));
    check("acc", int'(acc), exp_r);
    got_res  = int'(out_result);
    got_zero = int'(out_zero);
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      in_a = 4'hF;
      in_b = 4'hF;
      tick();
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_result", int'(out_result), exp_r);
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_alu_a", int'(alu_a), exp_a);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    m_acc = exp_r;
    m_cnt = (m_cnt + 1) % CMOD;
    check("release_out_valid", int'(out_valid), 0);
    check("release_in_ready", int'(in_ready), 1);
    check("op_count", int'(op_count), m_cnt);
    out_ready = 1'b0;
  endtask

  typedef struct {
    int a, b, op, accsel, stall;
    int exp_res, exp_zero, exp_cnt;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, z;
    vecs[0] = '{a: 3,  b: 4,  op: 0, accsel: 0, stall: 0, exp_res: 7,  exp_zero: 0, exp_cnt: 1};
    vecs[1] = '{a: 0,  b: 9,  op: 0, accsel: 1, stall: 0, exp_res: 0,  exp_zero: 1, exp_cnt: 2};
    vecs[2] = '{a: 2,  b: 5,  op: 1, accsel: 0, stall: 4, exp_res: 13, exp_zero: 0, exp_cnt: 3};
    vecs[3] = '{a: 12, b: 10, op: 2, accsel: 0, stall: 1, exp_res: 8,  exp_zero: 0, exp_cnt: 0};
    vecs[4] = '{a: 12, b: 3,  op: 3, accsel: 0, stall: 0, exp_res: 15, exp_zero: 0, exp_cnt: 1};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_op = '0;
    in_acc = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_acc", int'(acc), 0);
    check("rst_op_count", int'(op_count), 0);
    check("rst_alu_a", int'(alu_a), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      run_cmd(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].accsel, vecs[i].stall, r, z);
      check($sformatf("vec%0d_result", i), r, vecs[i].exp_res);
      check($sformatf("vec%0d_zero", i), z, vecs[i].exp_zero);
      check($sformatf("vec%0d_count", i), int'(op_count), vecs[i].exp_cnt);
    end

    // out_ready while idle must not advance the counter.
    out_ready = 1'b1;
    repeat (3) tick();
    check("idle_ready_count", int'(op_count), m_cnt);
    check("idle_ready_valid", int'(out_valid), 0);
    out_ready = 1'b0;

    // A command held through EXEC/HOLD is accepted three edges after the first.
    in_valid = 1'b1;
    in_a = 4'd1;
    in_b = 4'd1;
    in_op = 2'b00;
    in_acc = 1'b0;
    out_ready = 1'b1;
    tick();
    in_a = 4'd5;
    in_b = 4'd2;
    tick();
    check("b2b_capture", int'(out_result), 2);
    tick();
    m_cnt = (m_cnt + 1) % CMOD;
    check("b2b_idle_ready", int'(in_ready), 1);
    check("b2b_alu_a_hold", int'(alu_a), 1);
    check("b2b_count1", int'(op_count), m_cnt);
    tick();
    in_valid = 1'b0;
    check("b2b_alu_a_new", int'(alu_a), 5);
    check("b2b_in_ready", int'(in_ready), 0);
    tick();
    check("b2b_result2", int'(out_result), 7);
    tick();
    m_cnt = (m_cnt + 1) % CMOD;
    m_acc = 7;
    check("b2b_count2", int'(op_count), m_cnt);
    out_ready = 1'b0;

    // Reset while holding a result discards it asynchronously.
    in_valid = 1'b1;
    in_a = 4'd6;
    in_b = 4'd1;
    in_op = 2'b00;
    tick();
    in_valid = 1'b0;
    tick();
    check("pre_rst_valid", int'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_result", int'(out_result), 0);
    check("mid_rst_acc", int'(acc), 0);
    check("mid_rst_count", int'(op_count), 0);
    check("mid_rst_alu_a", int'(alu_a), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    m_acc = 0;
    m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", int'(in_ready), 1);
    check("post_rst_count", int'(op_count), 0);
    run_cmd(4, 4, 0, 1, 0, r, z);

    for (int i = 0; i < 40; i++) begin
      run_cmd(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(3)),
              int'($urandom_range(1)), int'($urandom_range(2)), r, z);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
